// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC access scheduler: FSM states, op kinds,
// fixed register map, init sequence and read-list helpers.
package rtc_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT
    } state_e;

    typedef enum logic [1:0] {
        OP_INIT,
        OP_READ,
        OP_WRITE
    } op_kind_e;

    localparam logic [7:0] RTC_ADDR_SEG    = 8'h21;
    localparam logic [7:0] RTC_ADDR_MIN    = 8'h22;
    localparam logic [7:0] RTC_ADDR_HORA   = 8'h23;
    localparam logic [7:0] RTC_ADDR_DIA    = 8'h24;
    localparam logic [7:0] RTC_ADDR_MES    = 8'h25;
    localparam logic [7:0] RTC_ADDR_ANIO   = 8'h26;
    localparam logic [7:0] RTC_ADDR_STATUS = 8'h02;

    localparam logic [7:0] INIT_DATA0 = 8'h10;
    localparam logic [7:0] INIT_DATA1 = 8'h00;

    localparam int N_READ = 6;
    localparam int N_INIT = 2;

    // Read list is contiguous, so slot idx maps straight onto an address offset.
    function automatic logic [7:0] read_addr(input logic [2:0] idx);
        return RTC_ADDR_SEG + {5'd0, idx};
    endfunction

    function automatic logic [7:0] init_data(input logic [1:0] idx);
        return (idx == 2'd0) ? INIT_DATA0 : INIT_DATA1;
    endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh timer; wrap is high during the last count of each period.
module rtc_refresh_timer #(
    parameter int unsigned PERIOD = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic wrap
);

    localparam logic [31:0] LAST = 32'(PERIOD - 1);

    logic [31:0] count;

    assign wrap = (count == LAST);

    // NOTE: state is updated with <= so every flop samples pre-edge values; = here would race.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/rtc_access_scheduler.sv
// Sequencer/arbiter for the RTC bus engine: init writes, periodic coherent
// time/date read bursts, and user single-byte writes slotted between transactions.
module rtc_access_scheduler
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       err_clr,
    input  logic [7:0] rtc_rdata,
    input  logic       rtc_done,
    output logic [7:0] rtc_addr,
    output logic [7:0] rtc_wdata,
    output logic       rtc_wr_rd,
    output logic       rtc_start,
    output logic       wr_ack,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic       time_valid,
    output logic       busy,
    output logic       err
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  RD_LAST  = 3'(N_READ - 1);
    localparam logic [1:0]  INIT_END = 2'(N_INIT);

    state_e     state, next_state;
    op_kind_e   op_kind, arb_kind;
    logic       arb_go, arb_new_burst;
    logic [7:0] arb_addr, arb_data;
    logic [1:0] init_idx;
    logic [2:0] rd_idx;
    logic       burst_active, refresh_pending, refresh_wrap;
    logic [15:0] tmo_cnt;
    logic       tmo_hit, wait_end, accept;
    logic [7:0] shadow [N_READ-1];

    rtc_refresh_timer #(.PERIOD(REFRESH_CYCLES)) u_refresh_timer (
        .clk   (clk),
        .reset (reset),
        .wrap  (refresh_wrap)
    );

    // NOTE: every variable gets a default before the if-chain so no path leaves it unassigned (no latch).
    always_comb begin
        arb_go        = 1'b1;
        arb_kind      = OP_INIT;
        arb_addr      = RTC_ADDR_STATUS;
        arb_data      = init_data(init_idx);
        arb_new_burst = 1'b0;
        if (init_idx != INIT_END) begin
            arb_kind = OP_INIT;
        // The requester still holds wr_req during its ack cycle; don't re-accept it.
        end else if (wr_req && !wr_ack) begin
            arb_kind = OP_WRITE;
            arb_addr = wr_addr;
            arb_data = wr_data;
        end else if (burst_active) begin
            arb_kind = OP_READ;
            arb_addr = read_addr(rd_idx);
            arb_data = 8'h00;
        end else if (refresh_pending) begin
            arb_kind      = OP_READ;
            arb_addr      = read_addr(3'd0);
            arb_data      = 8'h00;
            arb_new_burst = 1'b1;
        end else begin
            arb_go = 1'b0;
        end
    end

    assign accept   = arb_go && (state == S_INIT || state == S_IDLE || state == S_NEXT);
    assign tmo_hit  = (state == S_WAIT) && !rtc_done && (tmo_cnt == TMO_LAST);
    assign wait_end = (state == S_WAIT) && (rtc_done || tmo_hit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_INIT;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_INIT:         next_state = S_ISSUE;
            S_IDLE, S_NEXT: next_state = arb_go ? S_ISSUE : S_IDLE;
            S_ISSUE:        next_state = S_WAIT;
            S_WAIT:         next_state = wait_end ? S_NEXT : S_WAIT;
            default:        next_state = S_INIT;
        endcase
    end

    always_comb begin
        rtc_start = (state == S_ISSUE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_kind      <= OP_INIT;
            rtc_addr     <= '0;
            rtc_wdata    <= '0;
            rtc_wr_rd    <= 1'b0;
            init_idx     <= '0;
            rd_idx       <= '0;
            burst_active <= 1'b0;
            wr_ack       <= 1'b0;
            time_valid   <= 1'b0;
            {seg, min, hora, dia, mes, anio} <= '0;
            // NOTE: the shadow array is only five bytes, so it is reset like any other register.
            for (int i = 0; i < N_READ - 1; i++) shadow[i] <= '0;
        end else begin
            wr_ack     <= 1'b0;
            time_valid <= 1'b0;
            if (accept) begin
                op_kind   <= arb_kind;
                rtc_addr  <= arb_addr;
                rtc_wdata <= arb_data;
                rtc_wr_rd <= (arb_kind != OP_READ);
                if (arb_new_burst) begin
                    burst_active <= 1'b1;
                    rd_idx       <= '0;
                end
            end
            if (wait_end) begin
                unique case (op_kind)
                    OP_INIT:  init_idx <= init_idx + 2'd1;
                    OP_WRITE: wr_ack   <= 1'b1;
                    OP_READ: begin
                        if (!rtc_done) begin
                            burst_active <= 1'b0;
                            rd_idx       <= '0;
                        end else if (rd_idx == RD_LAST) begin
                            seg          <= shadow[0];
                            min          <= shadow[1];
                            hora         <= shadow[2];
                            dia          <= shadow[3];
                            mes          <= shadow[4];
                            anio         <= rtc_rdata;
                            time_valid   <= 1'b1;
                            burst_active <= 1'b0;
                            rd_idx       <= '0;
                        end else begin
                            shadow[rd_idx] <= rtc_rdata;
                            rd_idx         <= rd_idx + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt         <= '0;
            err             <= 1'b0;
            refresh_pending <= 1'b0;
            busy            <= 1'b0;
        end else begin
            tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 16'd1 : 16'd0;
            if (tmo_hit)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
            if (refresh_wrap)                   refresh_pending <= 1'b1;
            else if (accept && arb_new_burst)   refresh_pending <= 1'b0;
            busy <= (next_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Directed bench for rtc_access_scheduler with a behavioural RTC engine model.
module tb_rtc_access_scheduler;

    logic       clk = 1'b0;
    logic       reset, wr_req, err_clr, rtc_done;
    logic [7:0] wr_addr, wr_data, rtc_rdata;
    logic [7:0] rtc_addr, rtc_wdata, seg, min, hora, dia, mes, anio;
    logic       rtc_wr_rd, rtc_start, wr_ack, time_valid, busy, err;

    int checks = 0;
    int failures = 0;

    rtc_access_scheduler #(.REFRESH_CYCLES(200), .TIMEOUT_CYCLES(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .err_clr    (err_clr),
        .rtc_rdata  (rtc_rdata),
        .rtc_done   (rtc_done),
        .rtc_addr   (rtc_addr),
        .rtc_wdata  (rtc_wdata),
        .rtc_wr_rd  (rtc_wr_rd),
        .rtc_start  (rtc_start),
        .wr_ack     (wr_ack),
        .seg        (seg),
        .min        (min),
        .hora       (hora),
        .dia        (dia),
        .mes        (mes),
        .anio       (anio),
        .time_valid (time_valid),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] tod();
        return {seg, min, hora, dia, mes, anio};
    endfunction

    function automatic logic [16:0] op_w(input logic [7:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [16:0] op_r(input logic [7:0] a);
        return {1'b0, a, 8'h00};
    endfunction

    // Engine model: logs every start, answers after eng_lat cycles, can withhold one 0x24 read.
    logic [16:0] op_log [$];
    logic [7:0]  rd_vals [6];
    int          eng_lat = 20;
    logic        withhold_en = 1'b0;
    int          epoch = 0;
    int          eng_epoch, eng_idx;
    logic [7:0]  eng_addr;
    logic        eng_wr;

    initial begin
        rtc_done  = 1'b0;
        rtc_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset && rtc_start) begin
                eng_epoch = epoch;
                eng_addr  = rtc_addr;
                eng_wr    = rtc_wr_rd;
                op_log.push_back({rtc_wr_rd, rtc_addr, rtc_wr_rd ? rtc_wdata : 8'h00});
                if (withhold_en && !eng_wr && eng_addr == 8'h24) begin
                    withhold_en = 1'b0;
                end else begin
                    for (int k = 0; k < eng_lat; k++) begin
                        @(negedge clk);
                        if (epoch != eng_epoch) break;
                    end
                    if (epoch == eng_epoch) begin
                        eng_idx   = int'(eng_addr) - 33;
                        rtc_rdata = (eng_wr || eng_idx < 0 || eng_idx > 5) ? 8'h00 : rd_vals[eng_idx];
                        rtc_done  = 1'b1;
                        @(negedge clk);
                        rtc_done  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string tag, output int tvs, output int acks);
        int n = 0;
        tvs = 0;
        acks = 0;
        do begin
            @(negedge clk);
            n++;
            if (time_valid) tvs++;
            if (wr_ack) acks++;
        end while (busy && n < budget);
        check(tag, busy, 0);
    endtask

    task automatic wait_start(input logic [7:0] addr, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rtc_start && rtc_addr == addr) && n < budget);
        check(tag, {rtc_start, rtc_addr}, {1'b1, addr});
    endtask

    task automatic wait_tv(input int budget, input string tag, output int acks, output logic [47:0] prev);
        int n = 0;
        acks = 0;
        prev = tod();
        forever begin
            @(negedge clk);
            n++;
            if (wr_ack) begin
                acks++;
                wr_req = 1'b0;
            end
            if (time_valid || n >= budget) break;
            prev = tod();
        end
        check(tag, time_valid, 1);
    endtask

    int          base, tvs, acks, n, idle, starts;
    logic [47:0] prev;

    initial begin
        reset   = 1'b0;
        wr_req  = 1'b0;
        wr_addr = 8'h00;
        wr_data = 8'h00;
        err_clr = 1'b0;
        rd_vals = '{8'h45, 8'h30, 8'h12, 8'h17, 8'h05, 8'h16};

        // Reset state and init sequence
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", rtc_start, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {wr_ack, time_valid, err}, 0);
        check("rst_tod", tod(), 0);
        check("rst_op", {rtc_addr, rtc_wdata, rtc_wr_rd}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("init_cycle1_no_start", rtc_start, 0);
        @(negedge clk);
        check("init_start", {rtc_start, rtc_wr_rd, rtc_addr, rtc_wdata}, {1'b1, 1'b1, 8'h02, 8'h10});
        wait_idle(200, "init_idle", tvs, acks);
        check("init_count", op_log.size(), 2);
        check("init_op0", op_log[0], op_w(8'h02, 8'h10));
        check("init_op1", op_log[1], op_w(8'h02, 8'h00));
        check("init_err", err, 0);

        // First refresh burst
        base = op_log.size();
        wait_tv(400, "burst_tv", acks, prev);
        check("burst_tod", tod(), 48'h453012170516);
        check("burst_prev_tod", prev, 0);
        wait_idle(50, "burst_idle", tvs, acks);
        check("burst_single_tv", tvs, 0);
        check("burst_count", op_log.size() - base, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("burst_rd%0d", i), op_log[base + i], op_r(8'(8'h21 + i)));

        // User write interleaved after the 0x22 read
        rd_vals = '{8'h46, 8'h31, 8'h13, 8'h18, 8'h06, 8'h17};
        base = op_log.size();
        wait_start(8'h22, 400, "ilv_rd22_start");
        wr_addr = 8'h22;
        wr_data = 8'h59;
        wr_req  = 1'b1;
        wait_tv(400, "ilv_tv", acks, prev);
        check("ilv_ack_once", acks, 1);
        check("ilv_tod", tod(), 48'h463113180617);
        wait_idle(50, "ilv_idle", tvs, acks);
        check("ilv_single_tv", tvs, 0);
        check("ilv_no_late_ack", acks, 0);
        check("ilv_count", op_log.size() - base, 7);
        check("ilv_op1", op_log[base + 1], op_r(8'h22));
        check("ilv_op2", op_log[base + 2], op_w(8'h22, 8'h59));
        check("ilv_op3", op_log[base + 3], op_r(8'h23));
        check("ilv_op6", op_log[base + 6], op_r(8'h26));

        // Read timeout on 0x24 aborts the burst
        rd_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        withhold_en = 1'b1;
        wait_start(8'h24, 400, "tmo_rd24_start");
        n = 0;
        tvs = 0;
        do begin
            @(negedge clk);
            n++;
            if (time_valid) tvs++;
        end while (!err && n < 1200);
        check("tmo_latency", n, 1025);
        check("tmo_err", err, 1);
        check("tmo_no_tv", tvs, 0);
        check("tmo_hold_tod", tod(), 48'h463113180617);
        @(negedge clk);
        check("tmo_new_burst", {rtc_start, rtc_addr}, {1'b1, 8'h21});
        check("err_sticky", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", err, 0);
        wait_tv(400, "post_tmo_tv", acks, prev);
        check("post_tmo_tod", tod(), 48'h112233445566);

        // Engine slower than the refresh period
        eng_lat = 250;
        wait_tv(2500, "b2b_tv1", acks, prev);
        @(negedge clk);
        check("b2b_gap1", {rtc_start, rtc_addr}, {1'b1, 8'h21});
        n = 0;
        idle = 0;
        do begin
            @(negedge clk);
            n++;
            if (!busy) idle++;
        end while (!time_valid && n < 2000);
        check("b2b_tv2", time_valid, 1);
        check("b2b_no_idle", idle, 0);
        eng_lat = 5;
        @(negedge clk);
        check("b2b_gap2", {rtc_start, rtc_addr}, {1'b1, 8'h21});
        starts = 1;
        repeat (299) begin
            @(negedge clk);
            if (rtc_start && rtc_addr == 8'h21) starts++;
        end
        check("no_accum", starts <= 3, 1);

        // Async reset in the middle of a user write
        eng_lat = 20;
        wait_idle(300, "pre_arst_idle", tvs, acks);
        base = op_log.size();
        wr_addr = 8'h30;
        wr_data = 8'h77;
        wr_req  = 1'b1;
        wait_start(8'h30, 10, "arst_wr_start");
        repeat (5) @(negedge clk);
        reset  = 1'b0;
        epoch++;
        wr_req = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_start", rtc_start, 0);
        check("arst_flags", {wr_ack, time_valid, err}, 0);
        check("arst_op", {rtc_addr, rtc_wdata, rtc_wr_rd}, 0);
        check("arst_tod", tod(), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        wait_idle(200, "arst_init_idle", tvs, acks);
        check("arst_no_ack", acks, 0);
        check("arst_count", op_log.size() - base, 3);
        check("arst_op0", op_log[base], op_w(8'h30, 8'h77));
        check("arst_op1", op_log[base + 1], op_w(8'h02, 8'h10));
        check("arst_op2", op_log[base + 2], op_w(8'h02, 8'h00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_access_scheduler.md
# rtc_access_scheduler

Sequencer and arbiter for the RTC bus read/write engine (multiplexed A/D bus with `a_d`/`cs`/`rd`/`wr` strobes). After reset it runs the RTC initialization writes, then periodically bursts reads of the six time/date registers into a coherent shadow set. It also interleaves single-byte user write requests, for example from the configuration FSM, between engine transactions. It sits between the user logic and the engine's `addr_RAM`/`in_dato`/`escribir_leer`/`en_funcion` and `out_dato`/`fin_lectura_escritura` ports.

## Interface
- `REFRESH_CYCLES`, 100000 — period of refresh requests, in clk cycles; 32-bit counter.
- `TIMEOUT_CYCLES`, 1024 — maximum wait for `rtc_done` per transaction; 16-bit counter.
- `clk` in 1 — single system clock, rising edge.
- `reset` in 1 — asynchronous, active-low; asserted when 0.
- `wr_req` in 1 — user write request; held high until `wr_ack`.
- `wr_addr` in 8 — RTC register address; sampled when the write is accepted.
- `wr_data` in 8 — write data; sampled with `wr_addr`.
- `err_clr` in 1 — clears `err`.
- `rtc_rdata` in 8 — engine read data (`out_dato`).
- `rtc_done` in 1 — engine completion pulse (`fin_lectura_escritura`).
- `rtc_addr` out 8 — engine address.
- `rtc_wdata` out 8 — engine write data.
- `rtc_wr_rd` out 1 — 1 = write, 0 = read.
- `rtc_start` out 1 — one-cycle start pulse (`en_funcion`).
- `wr_ack` out 1 — one-cycle pulse when the user write finishes.
- `seg`, `min`, `hora`, `dia`, `mes`, `anio` out 8 each — BCD time/date.
- `time_valid` out 1 — one-cycle pulse when the shadow set is updated.
- `busy` out 1 — high in any state except S_IDLE.
- `err` out 1 — sticky timeout flag.

## Operation
- Init sequence, fixed: write 0x02←0x10, then write 0x02←0x00.
- Read list, fixed order: 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anio.
- States:
  - S_INIT: select init entry 0..1 → S_ISSUE.
  - S_IDLE: arbitrate.
  - S_ISSUE: latch op, pulse `rtc_start` → S_WAIT.
  - S_WAIT: hold op until `rtc_done` or timeout → S_NEXT.
  - S_NEXT: capture/advance, arbitrate.
- Arbitration in S_IDLE and S_NEXT, in priority order:
  1. Remaining init entries.
  2. Pending `wr_req`.
  3. Next read of an in-progress burst.
  4. Start a new burst if `refresh_pending`.
  5. Otherwise S_IDLE.
- User writes are never preempted and never preempt an engine transaction. They are inserted between burst reads, and the burst resumes at the next index.
- Reads capture `rtc_rdata` into shadow slot `idx` on the `rtc_done` cycle. After slot 5 is captured, all six shadow values copy to the outputs at once and `time_valid` pulses.
- Refresh timer: free-running, wraps at `REFRESH_CYCLES-1`, and sets `refresh_pending` on wrap. Pending is cleared when a burst starts. A wrap while pending stays set, with no counting or queueing.
- Timeout: at `TIMEOUT_CYCLES` in S_WAIT without `rtc_done`:
  - `err`←1 and the op is abandoned.
  - A write still pulses `wr_ack`.
  - A read aborts the whole burst: no `time_valid`, outputs unchanged, return to arbitration.
  - An init timeout proceeds to the next entry.
- `err` is cleared by `err_clr`. If set and clear coincide, set wins.
- `rtc_done` outside S_WAIT is ignored.

## Timing
- Reset values: all outputs 0; state S_INIT; `idx`=0; counters 0; `refresh_pending`=0. Reset mid-transaction abandons it, and init reruns after release.
- `rtc_start` is high exactly one cycle, in S_ISSUE.
- `rtc_addr`, `rtc_wdata` and `rtc_wr_rd` are valid from S_ISSUE and stable until the S_NEXT cycle.
- `wr_ack` and `time_valid` are registered and go high the cycle after `rtc_done` is seen.
- Minimum gap between consecutive `rtc_start` pulses: S_NEXT→S_ISSUE, so at least 2 cycles after `rtc_done`.
- `wr_req` sampled high in S_IDLE/S_NEXT → `rtc_start` the next cycle.
- The first init `rtc_start` occurs 2 cycles after `reset` deasserts.

## Structure
- Package `rtc_pkg`:
  - State enum.
  - Op-kind enum {INIT, READ, WRITE}.
  - Constants `RTC_ADDR_SEG`..`RTC_ADDR_ANIO`, `RTC_ADDR_STATUS`, `INIT_DATA0`/`INIT_DATA1`, `N_READ`=6.
- Sub-module `rtc_refresh_timer`: parameterized counter producing the wrap pulse.
- The FSM, arbitration and shadow registers live in the top module.

## Test plan
- **Reset/init:** release reset; engine model acks after 20 cycles → writes (0x02,0x10) then (0x02,0x00) in order; `busy` falls afterwards.
- **Burst:** `REFRESH_CYCLES`=200; engine returns 0x45,0x30,0x12,0x17,0x05,0x16 → six reads 0x21..0x26; single `time_valid`; outputs equal those values simultaneously.
- **Interleave:** assert `wr_req` (0x22←0x59) during the read of 0x22 → next op is the write, then a read of 0x23; `wr_ack` exactly once; burst completes.
- **Timeout:** engine withholds `rtc_done` on the 0x24 read → `err`=1 after 1024 cycles; no `time_valid`; outputs hold their old values; `err_clr` clears `err`.
- **Back-to-back refresh:** engine latency exceeds `REFRESH_CYCLES` → pending bursts do not accumulate, and bursts run back-to-back without gaps.
- **Async reset:** pulse `reset` low mid-write → all outputs 0 immediately; no `wr_ack`; init reruns.
